data_mem_access_unit: RTL and testbench
=======================================

// Module: data_mem_access_unit
// PURPOSE
//   Memory stage of the KGP-RISC core: consumes the ALU result (byte address) and register read_2
//   (store data) under Memread/MemWrite control, and returns load data to the write-back mux.
//   Wraps a word-organised synchronous data RAM behind a valid/ready handshake.
//   Raises busy so the core can stall the program counter.
//   Flags misaligned and out-of-range accesses instead of corrupting memory.
// PARAMETERS
//   ADDR_WIDTH  10  word-address bits; RAM depth = 2**ADDR_WIDTH words, legal byte range 0..4*2**ADDR_WIDTH-1
//   DATA_WIDTH  32  word width; fixed at 32 for KGP-RISC, kept as a parameter for bench sizing only
// PORTS
//   clock        in   1   single system clock, all state on rising edge
//   reset        in   1   asynchronous, active-high; clears FSM and outputs, not RAM contents
//   req_valid    in   1   core presents a memory request this cycle
//   req_ready    out  1   unit can accept a request this cycle
//   mem_read     in   1   request is a load (Memread)
//   mem_write    in   1   request is a store (MemWrite)
//   address      in   32  byte address (alu_out)
//   write_data   in   32  store data (read_2)
//   resp_valid   out  1   one-cycle pulse: response available
//   data_output  out  32  load data; held until next response
//   addr_error   out  1   qualifies resp_valid: request was rejected
//   busy         out  1   == ~req_ready; stall request to PC
// BEHAVIOUR
//   Reset (async, any time): state=IDLE, req_ready=1, resp_valid=0, data_output=0, addr_error=0; an
//     in-flight read is abandoned, and no RAM write occurs at or after the reset edge.
//   Accept: handshake completes on a rising edge where req_valid && req_ready; inputs are sampled
//     there and may change afterwards.
//   Legality: error if address[1:0]!=0, or address[31:ADDR_WIDTH+2]!=0, or mem_read&&mem_write.
//     Word index = address[ADDR_WIDTH+1:2].
//   Accept with neither mem_read nor mem_write: legal no-op; respond like a store, RAM unchanged.
//   FSM states and transitions:
//     IDLE  -> RD_WAIT   legal load accepted; RAM read issued on the accept edge
//     IDLE  -> ACK       legal store (RAM written on the accept edge) or legal no-op
//     IDLE  -> ERR       illegal request accepted; RAM untouched
//     RD_WAIT -> RESP    RAM data captured into data_output
//     RESP, ACK, ERR -> IDLE   after one cycle
//   Outputs by state:
//     RESP: resp_valid=1, addr_error=0, data_output = RAM word
//     ACK:  resp_valid=1, addr_error=0, data_output unchanged
//     ERR:  resp_valid=1, addr_error=1, data_output=0
//     req_ready=1 only in IDLE; busy=1 in every other state.
//   Latency, counted from the accept edge:
//     load: resp_valid high in the 2nd cycle after the accept edge
//     store, no-op, error: resp_valid high in the 1st cycle after the accept edge
//     throughput: one request per 3 cycles (load), per 2 cycles (other)
//   Requests arriving while req_ready=0 are not accepted; the requester must hold req_valid and its
//     fields until accepted.
//   addr_error is 0 whenever resp_valid=0.
//   Read-after-write: a load to a word stored by an earlier accepted request returns the new data;
//     no forwarding is needed because requests never overlap.
//   Address wrap: none; bits above the RAM range are an error, not aliased.
// TESTING
//   1 Reset, then store 0xDEADBEEF @0x0000_0010 -> resp_valid 1 cycle later, addr_error=0;
//     then load @0x10 -> resp_valid 2 cycles after accept, data_output=0xDEADBEEF.
//   2 Load @0x0000_0013 (misaligned) -> ERR: resp_valid=1, addr_error=1, data_output=0;
//     a following load @0x10 still returns the old word.
//   3 Store @0x0000_1000 with ADDR_WIDTH=10 (out of range) -> addr_error=1;
//     load @0x0 afterwards shows word 0 unchanged (no alias).
//   4 mem_read=mem_write=1 @0x20 -> addr_error=1, RAM @0x20 unchanged.
//     Hold req_valid high continuously: requests are accepted only when req_ready=1, spacing 2/3 cycles.
//   5 Store to the last word (0x0000_0FFC = 0x12345678) and first word (0x0 = 0xCAFEF00D);
//     load back both -> exact values, no cross-corruption.
//   6 Assert reset asynchronously during RD_WAIT -> all outputs 0 and req_ready=1 immediately,
//     no resp_valid pulse, prior RAM contents intact on a subsequent load.

Source files
------------

// File: rtl/data_mem_access_unit_if.sv
// Request/response bundle between the core's memory stage and the data memory access unit.
// The core drives the master side; the unit implements the slave side.
interface data_mem_access_unit_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  mem_read;
    logic                  mem_write;
    logic [31:0]           address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] data_output;
    logic                  addr_error;
    logic                  busy;

    modport master (
        output req_valid, mem_read, mem_write, address, write_data,
        input  req_ready, resp_valid, data_output, addr_error, busy
    );

    modport slave (
        input  req_valid, mem_read, mem_write, address, write_data,
        output req_ready, resp_valid, data_output, addr_error, busy
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// Memory stage of the KGP-RISC core: word-organised synchronous data RAM behind a valid/ready
// handshake, with misaligned / out-of-range / conflicting requests rejected before touching RAM.
module data_mem_access_unit #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 32
) (
    input logic                   clock,
    input logic                   reset,
    data_mem_access_unit_if.slave bus
);
    localparam int unsigned Depth = 1 << ADDR_WIDTH;
    localparam int unsigned HiBit = ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        StIdle,
        StRdWait,
        StResp,
        StAck,
        StErr
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] ram [Depth];

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  accept;
    logic                  illegal;
    logic                  ram_we;
    logic                  ram_re;

    always_comb begin
        word_idx = bus.address[ADDR_WIDTH+1:2];
        // Address bits above the RAM range are rejected rather than aliased.
        illegal  = (bus.address[1:0] != 2'b00)
                || ((bus.address >> HiBit) != 32'd0)
                || (bus.mem_read && bus.mem_write);
        accept   = bus.req_valid && (state_q == StIdle);
        // Reset blocks the RAM write even on an edge where reset is still high.
        ram_we   = accept && !illegal && bus.mem_write && !reset;
        ram_re   = accept && !illegal && bus.mem_read;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (illegal) begin
                        state_d = StErr;
                        data_d  = '0;
                    end else if (bus.mem_read) begin
                        state_d = StRdWait;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StRdWait: begin
                state_d = StResp;
                data_d  = rd_data_q;
            end
            StResp, StAck, StErr: state_d = StIdle;
            default:              state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // RAM contents survive reset, so the array and its read register carry no reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[word_idx] <= bus.write_data;
        end
        if (ram_re) begin
            rd_data_q <= ram[word_idx];
        end
    end

    assign bus.req_ready   = (state_q == StIdle);
    assign bus.busy        = (state_q != StIdle);
    assign bus.resp_valid  = (state_q == StResp) || (state_q == StAck) || (state_q == StErr);
    assign bus.addr_error  = (state_q == StErr);
    assign bus.data_output = data_q;

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Self-checking bench for data_mem_access_unit: table of requests with a response scoreboard,
// plus hand-written throughput and reset-during-read sequences.
module tb_data_mem_access_unit;
    logic clk;
    logic rst;

    data_mem_access_unit_if #(.DATA_WIDTH(32)) bus ();

    data_mem_access_unit #(
        .ADDR_WIDTH(10),
        .DATA_WIDTH(32)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [31:0] data;
        int          lat;
    } exp_t;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          err;
        logic [31:0] data;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;
    int   acc_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        exp_t e;
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1 && rst === 1'b0) acc_cyc = ncyc;
        if (bus.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp actual=resp_valid=1 required=no response (t=%0t)",
                         $time);
            end else begin
                e = sb.pop_front();
                check("addr_error", {31'd0, bus.addr_error}, {31'd0, e.err});
                check("data_output", bus.data_output, e.data);
                check("latency", ncyc - acc_cyc, e.lat);
            end
        end else begin
            check("addr_error_idle", {31'd0, bus.addr_error}, 32'd0);
        end
        ncyc++;
    end

    task automatic req(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input bit e_err, input logic [31:0] e_data, input bit hold,
                       output int acc_t);
        exp_t x;
        bit   rdy;
        int   n;
        x.err  = e_err;
        x.data = e_data;
        x.lat  = (rd && !e_err) ? 2 : 1;
        sb.push_back(x);
        bus.req_valid  = 1'b1;
        bus.mem_read   = rd;
        bus.mem_write  = wr;
        bus.address    = a;
        bus.write_data = wd;
        rdy = 1'b0;
        n   = 0;
        while (!rdy && n < 20) begin
            @(negedge clk);
            rdy = bus.req_ready;
            @(posedge clk);
            n++;
        end
        #2;
        acc_t = ncyc;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=not accepted required=accepted addr=%h", a);
        end
        if (!hold) begin
            bus.req_valid  = 1'b0;
            bus.mem_read   = 1'($urandom);
            bus.mem_write  = 1'($urandom);
            bus.address    = $urandom;
            bus.write_data = $urandom;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain", sb.size(), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
        check({tag, "_resp_valid"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, "_addr_error"}, {31'd0, bus.addr_error}, 32'd0);
        check({tag, "_data_output"}, bus.data_output, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t vecs[17];
        int   t0, t1, t2, t3;

        vecs[0]  = '{1'b0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0013, 32'h0,        1'b1, 32'h0000_0000};
        vecs[3]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h11111111, 1'b0, 32'hDEADBEEF};
        vecs[5]  = '{1'b0, 1'b1, 32'h0000_1000, 32'h55555555, 1'b1, 32'h0000_0000};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'h11111111};
        vecs[7]  = '{1'b0, 1'b1, 32'h0000_0020, 32'h20202020, 1'b0, 32'h11111111};
        vecs[8]  = '{1'b1, 1'b1, 32'h0000_0020, 32'h00000BAD, 1'b1, 32'h0000_0000};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 32'h20202020};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0030, 32'h77777777, 1'b0, 32'h20202020};
        vecs[11] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h12345678, 1'b0, 32'h20202020};
        vecs[12] = '{1'b0, 1'b1, 32'h0000_0000, 32'hCAFEF00D, 1'b0, 32'h20202020};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        1'b0, 32'h12345678};
        vecs[14] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,        1'b0, 32'hCAFEF00D};
        vecs[15] = '{1'b1, 1'b0, 32'h8000_0000, 32'h0,        1'b1, 32'h0000_0000};
        vecs[16] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,        1'b0, 32'h12345678};

        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.address    = '0;
        bus.write_data = '0;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("in_reset");
        rst = 1'b0;
        @(posedge clk);
        #2;
        check_reset_outputs("after_reset");

        for (int i = 0; i < 17; i++) begin
            req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                vecs[i].err, vecs[i].data, 1'b0, t0);
            wait_idle();
        end

        // Held req_valid: acceptance spacing follows the response latency of each request.
        req(1'b0, 1'b1, 32'h40, 32'h44, 1'b0, 32'h12345678, 1'b1, t0);
        req(1'b1, 1'b0, 32'h40, 32'h0,  1'b0, 32'h00000044, 1'b1, t1);
        req(1'b1, 1'b1, 32'h44, 32'h0,  1'b1, 32'h00000000, 1'b1, t2);
        req(1'b1, 1'b0, 32'h40, 32'h0,  1'b0, 32'h00000044, 1'b0, t3);
        wait_idle();
        check("spacing_store", t1 - t0, 32'd2);
        check("spacing_load", t2 - t1, 32'd3);
        check("spacing_error", t3 - t2, 32'd2);

        // Reset asynchronously while a load sits in RD_WAIT.
        req(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 1'b0, 32'h12345678, 1'b0, t0);
        check("in_rd_wait_busy", {31'd0, bus.busy}, 32'd1);
        #1;
        rst = 1'b1;
        #1;
        sb.delete();
        check_reset_outputs("async_reset");
        bus.req_valid  = 1'b1;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b1;
        bus.address    = 32'h0;
        bus.write_data = 32'hBADBAD00;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outputs("held_reset");
        bus.req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #2;
        req(1'b1, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 32'hCAFEF00D, 1'b0, t0);
        wait_idle();
        req(1'b1, 1'b0, 32'h0000_0FFC, 32'h0, 1'b0, 32'h12345678, 1'b0, t0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
